chip_spreader: RTL and testbench

Bit-to-chip DSSS spreader for the 2.4 GHz O-QPSK PHY. Sits directly downstream of the byte-to-bit `fifo`. It consumes the serial PHR/PSDU bit stream (`fifo_output`, `fifo_output_valid`, `data_end`), groups every 4 bits into a symbol and emits that symbol's 32-chip PN sequence serially, one chip per clock. It double-buffers so that consecutive symbols are emitted without gaps, and back-pressures the FIFO with `bit_ready`.

---
 rtl/chip_spreader.sv | 177 +++++++++++++++++
 tb/tb_chip_spreader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_spreader.sv
// chip_spreader: bit-to-chip DSSS spreader for the 2.4 GHz O-QPSK PHY.
//
// Collects the serial PHR/PSDU bit stream from the byte-to-bit fifo into
// 4-bit symbols (first bit = LSB) and emits each symbol's 32-chip PN sequence
// serially, one chip per clock, c0 first. A nibble collector and a symbol
// register form a double buffer, so consecutive symbols leave back-to-back.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high; clears every register
//   fifo_output       serial data bit
//   fifo_output_valid bit qualifier; accepted when fifo_output_valid && bit_ready
//   data_end          high with the final valid bit of the frame
//   bit_ready         spreader can accept a bit this cycle
//   chip_out          registered chip (IDLE_CHIP when chip_valid is low)
//   chip_valid        chip_out carries a real chip
//   symbol_count      symbols fully emitted in the current frame (saturating)
//   frame_done        one-cycle pulse in the cycle after the last chip
//   bit_error         (CHIP_SPREADER_ERR_EN only) sticky flag: a bit was
//                     offered while bit_ready was low
//
// Build option: define CHIP_SPREADER_ERR_EN to add the bit_error output.
// Without it, bits offered while bit_ready is low are silently dropped.

module chip_spreader #(
  parameter logic IDLE_CHIP = 1'b0,
  parameter int   CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_output,
  input  logic             fifo_output_valid,
  input  logic             data_end,
  output logic             bit_ready,
  output logic             chip_out,
  output logic             chip_valid,
  output logic [CNT_W-1:0] symbol_count,
  output logic             frame_done
`ifdef CHIP_SPREADER_ERR_EN
  ,
  output logic             bit_error
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Symbol 0 chip sequence, bit 31 = c0 (first chip on the air).
  localparam logic [31:0] SYM0_SEQ = 32'b11011001110000110101001000101110;
  // Odd-indexed chips c1, c3, ... sit on the even vector bits.
  localparam logic [31:0] ODD_MASK = 32'h5555_5555;

  logic [1:0]  state;
  logic [1:0]  bit_cnt;
  logic [3:0]  nibble;
  logic        full;
  logic        end_pending;
  logic [3:0]  sym_reg;
  logic [4:0]  chip_idx;

  logic        accept;
  logic        last_chip;
  logic        load;
  logic [4:0]  emit_idx;
  logic [31:0] emit_seq;
  logic        next_chip;

  // 16x32 chip lookup. A cyclic right shift of the chip sequence by 4k chips
  // is a right rotate of the vector by 4k bits (c0 lives at bit 31).
  function automatic logic [31:0] chip_seq(input logic [3:0] sym);
    logic [5:0]  sh;
    logic [31:0] rot;
    sh  = {1'b0, sym[2:0], 2'b00};
    rot = (SYM0_SEQ >> sh) | (SYM0_SEQ << (6'd32 - sh));
    return sym[3] ? (rot ^ ODD_MASK) : rot;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign bit_ready = !full && !end_pending;
  assign accept    = fifo_output_valid && bit_ready;
  assign last_chip = (state == ST_EMIT) && (chip_idx == 5'd31);
  assign load      = full && ((state == ST_IDLE) || last_chip);

  // One shared lookup: either chip 0 of the symbol being loaded or the next
  // chip of the symbol in flight.
  always_comb begin
    emit_idx  = load ? 5'd0 : chip_idx + 5'd1;
    emit_seq  = chip_seq(load ? nibble : sym_reg);
    next_chip = emit_seq[~emit_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 2'd0;
      nibble       <= 4'd0;
      full         <= 1'b0;
      end_pending  <= 1'b0;
      sym_reg      <= 4'd0;
      chip_idx     <= 5'd0;
      chip_out     <= IDLE_CHIP;
      chip_valid   <= 1'b0;
      symbol_count <= '0;
      frame_done   <= 1'b0;
    end else begin
      // Collector stage: accept and load are exclusive (load needs full,
      // accept needs !full). Clearing the nibble on load makes the
      // end-of-frame zero padding implicit.
      if (load) begin
        sym_reg <= nibble;
        nibble  <= 4'd0;
        bit_cnt <= 2'd0;
        full    <= 1'b0;
      end else if (accept) begin
        nibble[bit_cnt] <= fifo_output;
        bit_cnt         <= bit_cnt + 2'd1;
        if ((bit_cnt == 2'd3) || data_end) full <= 1'b1;
        if (data_end) end_pending <= 1'b1;
      end

      // Emitter stage: chip_idx is the index of the chip currently on chip_out.
      case (state)
        ST_IDLE: begin
          if (load) begin
            state      <= ST_EMIT;
            chip_idx   <= 5'd0;
            chip_out   <= next_chip;
            chip_valid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (chip_idx == 5'd31) begin
            symbol_count <= sat_inc(symbol_count);
            if (load) begin
              chip_idx <= 5'd0;
              chip_out <= next_chip;
            end else begin
              chip_out   <= IDLE_CHIP;
              chip_valid <= 1'b0;
              if (end_pending) begin
                state      <= ST_DONE;
                frame_done <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end else begin
            chip_idx <= emit_idx;
            chip_out <= next_chip;
          end
        end
        ST_DONE: begin
          frame_done   <= 1'b0;
          end_pending  <= 1'b0;
          symbol_count <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CHIP_SPREADER_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_error <= 1'b0;
    end else if (fifo_output_valid && !bit_ready) begin
      bit_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_chip_spreader.sv
// tb_chip_spreader: directed-vector bench for chip_spreader.
// Streams hand-picked bytes/bits into the spreader, captures every valid chip
// and compares whole 32-chip symbols, frame_done/symbol_count timing, reset
// behaviour and the optional bit_error flag against expected values.

module tb_chip_spreader;

  localparam logic [31:0] S0 = 32'b11011001110000110101001000101110;
  localparam logic [31:0] S7 = 32'b10011100001101010010001011101101;
  localparam logic [31:0] S8 = 32'b10001100100101100000011101111011;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_output;
  logic       fifo_output_valid;
  logic       data_end;
  logic       bit_ready;
  logic       chip_out;
  logic       chip_valid;
  logic [8:0] symbol_count;
  logic       frame_done;
`ifdef CHIP_SPREADER_ERR_EN
  logic       bit_error;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic cap_q[$];
  int   run_len  = 0;
  int   last_run = 0;
  int   fd_count = 0;

  chip_spreader dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_output       (fifo_output),
    .fifo_output_valid (fifo_output_valid),
    .data_end          (data_end),
    .bit_ready         (bit_ready),
    .chip_out          (chip_out),
    .chip_valid        (chip_valid),
    .symbol_count      (symbol_count),
    .frame_done        (frame_done)
`ifdef CHIP_SPREADER_ERR_EN
    ,
    .bit_error         (bit_error)
`endif
  );

  always #5 clk = ~clk;

  // Chip capture and contiguity tracking on the inactive edge.
  always @(negedge clk) begin
    if (chip_valid) begin
      cap_q.push_back(chip_out);
      run_len++;
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (frame_done) fd_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Expected chip sequence built chip by chip: c_j = s0 chip (j - 4k) mod 32,
  // odd chips inverted for k >= 8. Bit 31 holds c0.
  function automatic logic [31:0] exp_seq(input int k);
    logic [31:0] base;
    logic [31:0] r;
    int          src;
    base = S0;
    r    = '0;
    for (int j = 0; j < 32; j++) begin
      src       = (j - 4 * (k % 8) + 32) % 32;
      r[31 - j] = base[31 - src] ^ ((k >= 8) && (j % 2 == 1));
    end
    return r;
  endfunction

  task automatic check_sym(input string tag, input int slot, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (cap_q.size() >= (slot + 1) * 32) begin
      for (int j = 0; j < 32; j++) got[31 - j] = cap_q[slot * 32 + j];
    end
    check_vec(tag, got, exp);
  endtask

  task automatic push_bit(input logic b, input logic e);
    int g;
    g = 0;
    @(negedge clk);
    while (!bit_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check_vec("rdy_timeout", {31'b0, bit_ready}, 32'd1);
    fifo_output       = b;
    data_end          = e;
    fifo_output_valid = 1'b1;
    @(posedge clk);
    #1;
    fifo_output_valid = 1'b0;
    data_end          = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    for (int i = 0; i < 8; i++) push_bit(b[i], last && (i == 7));
  endtask

  task automatic wait_done(input string tag, input int n_sym, input int limit);
    int g;
    g = 0;
    while (!frame_done && g < limit) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_vec({tag, "_done"},   {31'b0, frame_done}, 32'd1);
    check_vec({tag, "_cv_low"}, {31'b0, chip_valid}, 32'd0);
    check_vec({tag, "_symcnt"}, {23'b0, symbol_count}, n_sym);
    @(posedge clk);
    #1;
    check_vec({tag, "_done_off"}, {31'b0, frame_done}, 32'd0);
    check_vec({tag, "_cnt_clr"},  {23'b0, symbol_count}, 32'd0);
    check_vec({tag, "_rdy"},      {31'b0, bit_ready}, 32'd1);
    check_vec({tag, "_run"},      last_run, n_sym * 32);
    check_vec({tag, "_nchips"},   cap_q.size(), n_sym * 32);
  endtask

  initial begin
    int order[16] = '{7, 0, 3, 0, 1, 0, 5, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    logic [7:0] frame2[8] = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
    int g, fd_before, acc;
    logic ready_now, first_low;

    reset = 1'b1;
    fifo_output = 1'b0;
    fifo_output_valid = 1'b0;
    data_end = 1'b0;
    #12;
    check_vec("rst_ready", {31'b0, bit_ready}, 32'd1);
    check_vec("rst_chip",  {31'b0, chip_out}, 32'd0);
    check_vec("rst_cv",    {31'b0, chip_valid}, 32'd0);
    check_vec("rst_cnt",   {23'b0, symbol_count}, 32'd0);
    check_vec("rst_fd",    {31'b0, frame_done}, 32'd0);
`ifdef CHIP_SPREADER_ERR_EN
    check_vec("rst_err",   {31'b0, bit_error}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Byte 0x07 -> symbols 7, 0 with first-chip latency check.
    cap_q.delete();
    for (int i = 0; i < 4; i++) push_bit(1'(i < 3), 1'b0);
    check_vec("t1_lat_cv0", {31'b0, chip_valid}, 32'd0);
    check_vec("t1_lat_rdy", {31'b0, bit_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_vec("t1_lat_cv1", {31'b0, chip_valid}, 32'd1);
    check_vec("t1_lat_c0",  {31'b0, chip_out}, 32'd1);
    for (int i = 4; i < 8; i++) push_bit(1'b0, i == 7);
    check_vec("t1_rdy_end", {31'b0, bit_ready}, 32'd0);
    wait_done("t1", 2, 200);
    check_sym("t1_sym7", 0, S7);
    check_sym("t1_sym0", 1, S0);

    // Eight bytes at full rate -> 16 gap-free symbols.
    cap_q.delete();
    for (int i = 0; i < 8; i++) push_byte(frame2[i], i == 7);
    wait_done("t2", 16, 800);
    for (int i = 0; i < 16; i++)
      check_sym($sformatf("t2_sym%0d", i), i, (i == 15) ? S8 : exp_seq(order[i]));

    // Six 1-bits with data_end on the sixth -> symbols F, 3 (zero pad).
    cap_q.delete();
    for (int i = 0; i < 6; i++) push_bit(1'b1, i == 5);
    wait_done("t3", 2, 200);
    check_sym("t3_symF", 0, exp_seq(15));
    check_sym("t3_sym3", 1, exp_seq(3));

    // Reset during chip 17 of the second symbol.
    cap_q.delete();
    push_byte(8'h00, 1'b1);
    g = 0;
    while (!(cap_q.size() == 49 && chip_valid) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_vec("t4_cnt_pre", {23'b0, symbol_count}, 32'd1);
    fd_before = fd_count;
    reset = 1'b1;
    #1;
    check_vec("t4_cv",   {31'b0, chip_valid}, 32'd0);
    check_vec("t4_cnt",  {23'b0, symbol_count}, 32'd0);
    check_vec("t4_fd",   {31'b0, frame_done}, 32'd0);
    check_vec("t4_rdy",  {31'b0, bit_ready}, 32'd1);
    check_vec("t4_chip", {31'b0, chip_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_vec("t4_no_fd", fd_count, fd_before);
    check_vec("t4_idle",  {31'b0, chip_valid}, 32'd0);
    cap_q.delete();
    push_byte(8'h00, 1'b1);
    wait_done("t4b", 2, 200);
    check_sym("t4b_sym0a", 0, S0);
    check_sym("t4b_sym0b", 1, S0);

    // Valid held high regardless of bit_ready; only accepted bits count.
    cap_q.delete();
    acc = 0;
    g = 0;
    first_low = 1'b0;
    fifo_output = 1'b1;
    fifo_output_valid = 1'b1;
    while (acc < 8 && g < 400) begin
      @(negedge clk);
      data_end  = (acc == 7);
      ready_now = bit_ready;
`ifdef CHIP_SPREADER_ERR_EN
      if (!ready_now && !first_low) check_vec("t5_err_pre", {31'b0, bit_error}, 32'd0);
`endif
      @(posedge clk);
      #1;
      if (ready_now) acc++;
`ifdef CHIP_SPREADER_ERR_EN
      if (!ready_now && !first_low) check_vec("t5_err_rise", {31'b0, bit_error}, 32'd1);
`endif
      if (!ready_now) first_low = 1'b1;
      g++;
    end
    fifo_output_valid = 1'b0;
    data_end = 1'b0;
    check_vec("t5_accepted", acc, 32'd8);
    wait_done("t5", 2, 200);
    check_sym("t5_symFa", 0, exp_seq(15));
    check_sym("t5_symFb", 1, exp_seq(15));
`ifdef CHIP_SPREADER_ERR_EN
    check_vec("t5_err_hold", {31'b0, bit_error}, 32'd1);
    reset = 1'b1;
    #1;
    check_vec("t5_err_clr", {31'b0, bit_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
